cp_operand_loader: RTL and testbench

Streaming front-end for the `crossproduct` stage. It accepts operand elements one per cycle over a valid/ready byte stream and assembles them into a shadow bank. It then transfers each completed operand set into a stable output bank that drives `crossproduct`'s `a1..a4` / `b1..b4` inputs directly, and holds it with `out_valid` until the consumer acknowledges. The double bank lets the next operand set load while the current one is being consumed.

---
 rtl/cp_pkg.sv | 23 ++
 rtl/cp_operand_loader.sv | 122 ++++++++++++
 tb/tb_cp_operand_loader.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cp_pkg.sv
// Shared constants and types for the crossproduct operand path.
// The element index constants fix the a1..a4, b1..b4 load order.
package cp_pkg;

  localparam int CP_WIDTH    = 8;
  localparam int CP_N_ELEM   = 4;
  localparam int CP_LOAD_CNT = 8;

  localparam int IDX_A1 = 0;
  localparam int IDX_A2 = 1;
  localparam int IDX_A3 = 2;
  localparam int IDX_A4 = 3;
  localparam int IDX_B1 = 4;
  localparam int IDX_B2 = 5;
  localparam int IDX_B3 = 6;
  localparam int IDX_B4 = 7;

  typedef enum logic {
    SH_FILL = 1'b0,
    SH_FULL = 1'b1
  } shadow_state_t;

endpackage

// File: rtl/cp_operand_loader.sv
// Streams eight operand elements into a shadow bank, then hands each complete
// set to a held output bank that drives crossproduct a1..a4 / b1..b4.
//
// state   | meaning
// SH_FILL | shadow bank accepting elements, load_cnt selects the slot
// SH_FULL | eight elements held, waiting for the output bank to free up
module cp_operand_loader
  import cp_pkg::*;
#(
  parameter int WIDTH = CP_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] a1,
  output logic [WIDTH-1:0] a2,
  output logic [WIDTH-1:0] a3,
  output logic [WIDTH-1:0] a4,
  output logic [WIDTH-1:0] b1,
  output logic [WIDTH-1:0] b2,
  output logic [WIDTH-1:0] b3,
  output logic [WIDTH-1:0] b4,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_tag
);

  localparam logic [2:0] LAST_SLOT = 3'(CP_LOAD_CNT - 1);

  shadow_state_t    state, state_next;
  logic [2:0]       load_cnt, load_cnt_next;
  logic [WIDTH-1:0] shadow [CP_LOAD_CNT];
  logic [7:0]       next_tag;
  logic             shadow_full;
  logic             accept;
  logic             transfer;

  assign shadow_full = (state == SH_FULL);
  assign in_ready    = !rst && !shadow_full && !flush;
  assign accept      = in_valid && in_ready;
  // A flush on the transfer edge discards the set rather than letting it through.
  assign transfer    = shadow_full && !flush && (!out_valid || out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= SH_FILL;
      load_cnt <= '0;
    end else begin
      state    <= state_next;
      load_cnt <= load_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    load_cnt_next = load_cnt;
    unique case (state)
      SH_FILL: begin
        if (flush) begin
          load_cnt_next = '0;
        end else if (accept) begin
          if (load_cnt == LAST_SLOT) begin
            load_cnt_next = '0;
            state_next    = SH_FULL;
          end else begin
            load_cnt_next = load_cnt + 3'd1;
          end
        end
      end
      SH_FULL: begin
        if (flush || transfer) state_next = SH_FILL;
      end
      default: begin
        state_next    = SH_FILL;
        load_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CP_LOAD_CNT; i++) shadow[i] <= '0;
    end else if (accept) begin
      shadow[load_cnt] <= in_data;
    end
  end

  // Output bank only moves on transfer; a consume just drops out_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a1        <= '0;
      a2        <= '0;
      a3        <= '0;
      a4        <= '0;
      b1        <= '0;
      b2        <= '0;
      b3        <= '0;
      b4        <= '0;
      out_valid <= 1'b0;
      out_tag   <= '0;
      next_tag  <= '0;
    end else if (transfer) begin
      a1        <= shadow[IDX_A1];
      a2        <= shadow[IDX_A2];
      a3        <= shadow[IDX_A3];
      a4        <= shadow[IDX_A4];
      b1        <= shadow[IDX_B1];
      b2        <= shadow[IDX_B2];
      b3        <= shadow[IDX_B3];
      b4        <= shadow[IDX_B4];
      out_valid <= 1'b1;
      out_tag   <= next_tag;
      next_tag  <= next_tag + 8'd1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cp_operand_loader.sv
// Self-checking bench for cp_operand_loader: directed tables and sequences,
// then randomized valid/ready traffic against a set-level scoreboard.
module tb_cp_operand_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       flush;
  logic [7:0] a1, a2, a3, a4, b1, b2, b3, b4;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_tag;

  cp_operand_loader #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush),
    .a1(a1), .a2(a2), .a3(a3), .a4(a4),
    .b1(b1), .b2(b2), .b3(b3), .b4(b4),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] bank();
    return {b4, b3, b2, b1, a4, a3, a2, a1};
  endfunction

  task automatic tick(output logic acc);
    #1;
    acc = in_valid && in_ready;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       exp_rdy;
    logic       exp_ov;
    logic [7:0] exp_tag;
  } vec_t;

  vec_t tbl[9];

  task automatic apply_table();
    for (int i = 0; i < 9; i++) begin
      in_valid  = tbl[i].iv;
      in_data   = tbl[i].d;
      out_ready = tbl[i].ordy;
      #1;
      chk("tbl_in_ready", 64'(in_ready), 64'(tbl[i].exp_rdy));
      @(posedge clk);
      #1;
      chk("tbl_out_valid", 64'(out_valid), 64'(tbl[i].exp_ov));
      chk("tbl_out_tag", 64'(out_tag), 64'(tbl[i].exp_tag));
    end
    in_valid = 1'b0;
    chk("basic_bank", bank(), 64'h07050301_06040200);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Set-level scoreboard: accepted elements grouped in eights, tags counted.
  logic        mon_en = 1'b0;
  logic [63:0] p_bank;
  int          p_cnt;
  logic [63:0] exp_q[$];
  logic [7:0]  m_tag;
  logic        m_pv;
  logic [7:0]  m_ptag;
  logic [63:0] m_pbank;
  int          sets_out;
  logic        pre_acc, pre_flush, pre_ordy;
  logic [7:0]  pre_d;
  logic        new_set;
  logic [63:0] cur;

  always @(posedge clk) begin
    if (mon_en && !rst) begin
      pre_acc   = in_valid && in_ready;
      pre_flush = flush;
      pre_ordy  = out_ready;
      pre_d     = in_data;
      if (pre_flush) begin
        p_cnt = 0;
        exp_q.delete();
      end
      #1;
      cur     = bank();
      new_set = out_valid && (!m_pv || out_tag != m_ptag);
      if (new_set) begin
        if (exp_q.size() == 0) begin
          chk("rand_unexpected_set", 64'(out_tag), 64'(m_tag));
          chk("rand_unexpected_set_present", 64'd1, 64'd0);
        end else begin
          chk("rand_set_data", cur, exp_q.pop_front());
          chk("rand_set_tag", 64'(out_tag), 64'(m_tag));
        end
        m_tag = m_tag + 8'd1;
        sets_out++;
      end else if (m_pv) begin
        if (out_valid) chk("rand_stable", cur, m_pbank);
        else chk("rand_consume_needs_ready", 64'(pre_ordy), 64'd1);
      end
      if (pre_acc) begin
        p_bank[p_cnt*8 +: 8] = pre_d;
        p_cnt++;
        if (p_cnt == 8) begin
          exp_q.push_back(p_bank);
          p_cnt = 0;
        end
      end
      m_pv    = out_valid;
      m_ptag  = out_tag;
      m_pbank = cur;
    end
  end

  logic acc;
  int   cnt;
  int   got;
  int   cyc;
  int   last_cyc;
  logic pv;
  logic [7:0] pt;

  initial begin
    for (int i = 0; i < 8; i++) begin
      tbl[i].iv      = 1'b1;
      tbl[i].d       = (i < 4) ? 8'(2 * i) : 8'(2 * (i - 4) + 1);
      tbl[i].ordy    = 1'b0;
      tbl[i].exp_rdy = 1'b1;
      tbl[i].exp_ov  = 1'b0;
      tbl[i].exp_tag = 8'd0;
    end
    tbl[8] = '{iv: 1'b0, d: 8'h00, ordy: 1'b0, exp_rdy: 1'b0, exp_ov: 1'b1, exp_tag: 8'd0};

    rst = 1'b1; in_data = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    #12;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_tag", 64'(out_tag), 64'd0);
    chk("reset_bank", bank(), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    do_reset();

    // Basic load
    apply_table();

    // Backpressure: 16 offered, only 8 fit in the shadow bank
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(100 + cnt);
      tick(acc);
      if (acc) cnt++;
    end
    chk("bp_accepts", 64'(cnt), 64'd8);
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    chk("bp_bank_held", bank(), 64'h07050301_06040200);
    chk("bp_tag_held", 64'(out_tag), 64'd0);
    out_ready = 1'b1;
    tick(acc);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("bp_b2b_valid", 64'(out_valid), 64'd1);
    chk("bp_b2b_tag", 64'(out_tag), 64'd1);
    chk("bp_b2b_bank", bank(), 64'h6B6A6968_67666564);

    // Consume then flush a partial set
    out_ready = 1'b1;
    tick(acc);
    out_ready = 1'b0;
    chk("consume_valid", 64'(out_valid), 64'd0);
    chk("consume_bank_kept", bank(), 64'h6B6A6968_67666564);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(200 + i);
      tick(acc);
      if (acc) cnt++;
    end
    chk("flush_pre_accepts", 64'(cnt), 64'd5);
    flush   = 1'b1;
    in_data = 8'd99;
    tick(acc);
    chk("flush_blocks_accept", 64'(acc), 64'd0);
    flush = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      in_data = 8'(210 + i);
      tick(acc);
      if (acc) cnt++;
    end
    in_valid = 1'b0;
    chk("flush_post_accepts", 64'(cnt), 64'd8);
    chk("flush_not_yet_valid", 64'(out_valid), 64'd0);
    tick(acc);
    chk("flush_set_valid", 64'(out_valid), 64'd1);
    chk("flush_set_tag", 64'(out_tag), 64'd2);
    chk("flush_set_bank", bank(), 64'hD9D8D7D6_D5D4D3D2);

    // Reset mid-hold with 3 shadow elements loaded
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h55;
      tick(acc);
    end
    in_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("rst_async_valid", 64'(out_valid), 64'd0);
    chk("rst_async_tag", 64'(out_tag), 64'd0);
    chk("rst_async_bank", bank(), 64'd0);
    chk("rst_async_in_ready", 64'(in_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    apply_table();

    // Tag wrap and sustained 9-cycle throughput
    do_reset();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    got = 0; cyc = 0; last_cyc = 0; pv = 1'b0; pt = 8'd0;
    while (got < 257 && cyc < 257 * 9 + 40) begin
      in_data = 8'($urandom);
      tick(acc);
      cyc++;
      if (out_valid && (!pv || out_tag != pt)) begin
        chk("wrap_tag", 64'(out_tag), 64'(got % 256));
        if (got > 0) chk("wrap_gap", 64'(cyc - last_cyc), 64'd9);
        last_cyc = cyc;
        got++;
      end
      pv = out_valid;
      pt = out_tag;
    end
    chk("wrap_sets_done", 64'(got), 64'd257);
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // Randomized traffic against the scoreboard
    do_reset();
    p_cnt = 0; p_bank = '0; exp_q.delete(); m_tag = 8'd0;
    m_pv = 1'b0; m_ptag = 8'd0; m_pbank = '0; sets_out = 0;
    mon_en = 1'b1;
    cyc = 0;
    while (sets_out < 1000 && cyc < 40000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      flush     = ($urandom_range(0, 99) == 0);
      out_ready = ($urandom_range(0, 1) == 1);
      tick(acc);
      cyc++;
    end
    mon_en    = 1'b0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    chk("rand_sets_done", 64'(sets_out >= 1000), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
